// File: rtl/nios2vga_gpio_pio.sv
// Avalon-MM general-purpose PIO: per-line direction, synchronised inputs, sticky edge capture, masked irq.
// Optional atomic set/clear registers at addresses 4/5 when NIOS2VGA_GPIO_SETCLR_EN is defined.
module nios2vga_gpio_pio #(
    parameter int          DATA_WIDTH = 18,
    parameter int          EDGE_TYPE  = 0,
    parameter logic [31:0] RESET_OUT  = 32'h0,
    parameter logic [31:0] RESET_DIR  = 32'h0
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [2:0]            address,
    input  logic                  chipselect,
    input  logic                  write_n,
    input  logic [31:0]           writedata,
    output logic [31:0]           readdata,
    input  logic [DATA_WIDTH-1:0] in_port,
    output logic [DATA_WIDTH-1:0] out_port,
    output logic [DATA_WIDTH-1:0] out_en,
    output logic                  irq
);

    localparam logic [2:0] ADDR_DATA    = 3'd0;
    localparam logic [2:0] ADDR_DIR     = 3'd1;
    localparam logic [2:0] ADDR_IRQMASK = 3'd2;
    localparam logic [2:0] ADDR_EDGECAP = 3'd3;
`ifdef NIOS2VGA_GPIO_SETCLR_EN
    localparam logic [2:0] ADDR_OUTSET  = 3'd4;
    localparam logic [2:0] ADDR_OUTCLR  = 3'd5;
`endif

    logic [DATA_WIDTH-1:0] r_out;
    logic [DATA_WIDTH-1:0] r_dir;
    logic [DATA_WIDTH-1:0] r_mask;
    logic [DATA_WIDTH-1:0] r_cap;
    logic [DATA_WIDTH-1:0] r_sync1;
    logic [DATA_WIDTH-1:0] r_sync_in;
    logic [DATA_WIDTH-1:0] r_prev;

    logic                  w_wr;
    logic [DATA_WIDTH-1:0] w_wdata;
    logic [DATA_WIDTH-1:0] w_edge;
    logic [DATA_WIDTH-1:0] w_cap_clr;
    logic [DATA_WIDTH-1:0] w_out_nxt;
    logic [DATA_WIDTH-1:0] w_rd_field;
    logic [31:0]           w_rd_ext;
    logic                  w_unused_wdata;

    assign w_wr           = chipselect & ~write_n;
    assign w_wdata        = writedata[DATA_WIDTH-1:0];
    assign w_unused_wdata = ^writedata;

    always_comb begin
        if (EDGE_TYPE == 0) begin
            w_edge = r_sync_in & ~r_prev;
        end else if (EDGE_TYPE == 1) begin
            w_edge = ~r_sync_in & r_prev;
        end else begin
            w_edge = r_sync_in ^ r_prev;
        end
    end

    assign w_cap_clr = (w_wr && (address == ADDR_EDGECAP)) ? w_wdata : '0;

    always_comb begin
        w_out_nxt = r_out;
        if (w_wr) begin
            case (address)
                ADDR_DATA:   w_out_nxt = w_wdata;
`ifdef NIOS2VGA_GPIO_SETCLR_EN
                ADDR_OUTSET: w_out_nxt = r_out | w_wdata;
                ADDR_OUTCLR: w_out_nxt = r_out & ~w_wdata;
`endif
                default:     w_out_nxt = r_out;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out     <= RESET_OUT[DATA_WIDTH-1:0];
            r_dir     <= RESET_DIR[DATA_WIDTH-1:0];
            r_mask    <= '0;
            r_cap     <= '0;
            r_sync1   <= '0;
            r_sync_in <= '0;
            r_prev    <= '0;
        end else begin
            r_out     <= w_out_nxt;
            r_sync1   <= in_port;
            r_sync_in <= r_sync1;
            r_prev    <= r_sync_in;
            // Edge is OR-ed in after the clear so a coincident edge keeps the bit set.
            r_cap     <= (r_cap & ~w_cap_clr) | w_edge;
            if (w_wr && (address == ADDR_DIR)) begin
                r_dir <= w_wdata;
            end
            if (w_wr && (address == ADDR_IRQMASK)) begin
                r_mask <= w_wdata;
            end
        end
    end

    always_comb begin
        case (address)
            ADDR_DATA:    w_rd_field = (r_out & r_dir) | (r_sync_in & ~r_dir);
            ADDR_DIR:     w_rd_field = r_dir;
            ADDR_IRQMASK: w_rd_field = r_mask;
            ADDR_EDGECAP: w_rd_field = r_cap;
            default:      w_rd_field = '0;
        endcase
        w_rd_ext                   = '0;
        w_rd_ext[DATA_WIDTH-1:0]   = w_rd_field;
        readdata                   = chipselect ? w_rd_ext : 32'h0;
    end

    assign out_port = r_out;
    assign out_en   = r_dir;
    assign irq      = |(r_cap & r_mask);

endmodule

// File: tb/tb_nios2vga_gpio_pio.sv
// Self-checking bench for nios2vga_gpio_pio: directed steps plus randomized traffic against a queue-based model.
module tb_nios2vga_gpio_pio;

    localparam int          DW    = 18;
    localparam logic [31:0] R_OUT = 32'h155;
    localparam logic [31:0] R_DIR = 32'h3FFFF;
    localparam logic [DW-1:0] ALL = '1;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic [2:0]    address = 3'd0;
    logic          chipselect = 1'b0;
    logic          write_n = 1'b1;
    logic [31:0]   writedata = 32'h0;
    logic [31:0]   readdata;
    logic [DW-1:0] in_port = '0;
    logic [DW-1:0] out_port;
    logic [DW-1:0] out_en;
    logic          irq;

    int checks = 0;
    int errors = 0;

    nios2vga_gpio_pio #(
        .DATA_WIDTH(DW),
        .EDGE_TYPE (0),
        .RESET_OUT (R_OUT),
        .RESET_DIR (R_DIR)
    ) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .address   (address),
        .chipselect(chipselect),
        .write_n   (write_n),
        .writedata (writedata),
        .readdata  (readdata),
        .in_port   (in_port),
        .out_port  (out_port),
        .out_en    (out_en),
        .irq       (irq)
    );

    always #5 clk = ~clk;

    // Reference model: register values plus a history of pin samples, newest first.
    logic [DW-1:0] m_out, m_dir, m_mask, m_cap;
    logic [DW-1:0] hist[$];

    function automatic void m_reset();
        m_out  = R_OUT[DW-1:0];
        m_dir  = R_DIR[DW-1:0];
        m_mask = '0;
        m_cap  = '0;
        hist.delete();
        repeat (3) hist.push_back('0);
    endfunction

    // Pins seen by software lag two clock samples; a rising edge is noticed one sample after that.
    function automatic void m_edge(input logic [DW-1:0] pins, input bit wr,
                                   input logic [2:0] a, input logic [31:0] wd);
        logic [DW-1:0] d;
        logic [DW-1:0] rose;
        d    = wd[DW-1:0];
        rose = hist[1] & ~hist[2];
        if (wr) begin
            if (a == 3'd0) m_out = d;
            if (a == 3'd1) m_dir = d;
            if (a == 3'd2) m_mask = d;
            if (a == 3'd3) m_cap = m_cap & ~d;
`ifdef NIOS2VGA_GPIO_SETCLR_EN
            if (a == 3'd4) m_out = m_out | d;
            if (a == 3'd5) m_out = m_out & ~d;
`endif
        end
        m_cap = m_cap | rose;
        hist.push_front(pins);
        void'(hist.pop_back());
    endfunction

    function automatic logic [31:0] m_read(input logic [2:0] a);
        logic [31:0] v;
        v = 32'h0;
        case (a)
            3'd0: v[DW-1:0] = (m_out & m_dir) | (hist[1] & ~m_dir);
            3'd1: v[DW-1:0] = m_dir;
            3'd2: v[DW-1:0] = m_mask;
            3'd3: v[DW-1:0] = m_cap;
            default: v = 32'h0;
        endcase
        return v;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic cyc(input bit wr, input logic [2:0] a, input logic [31:0] wd);
        chipselect = wr;
        write_n    = !wr;
        address    = a;
        writedata  = wd;
        @(posedge clk);
        m_edge(in_port, wr, a, wd);
        #1;
        chipselect = 1'b0;
        write_n    = 1'b1;
        chk("out_port", 32'(out_port), 32'(m_out));
        chk("out_en", 32'(out_en), 32'(m_dir));
        chk("irq", 32'(irq), 32'(|(m_cap & m_mask)));
    endtask

    task automatic rd(input logic [2:0] a, output logic [31:0] obs);
        chipselect = 1'b1;
        write_n    = 1'b1;
        address    = a;
        #1;
        obs = readdata;
        chk("readdata", readdata, m_read(a));
        chipselect = 1'b0;
        #1;
        chk("readdata_idle", readdata, 32'h0);
    endtask

    logic [31:0] v;

    initial begin
        m_reset();
        #12;
        chk("rst_out_port", 32'(out_port), 32'h155);
        chk("rst_out_en", 32'(out_en), 32'h3FFFF);
        chk("rst_irq", 32'(irq), 32'h0);
        chk("rst_rd_idle", readdata, 32'h0);
        rd(3'd3, v);
        chk("rst_edgecap", v, 32'h0);
        @(negedge clk);
        reset_n = 1'b1;

        // Output data write with all lines driven
        cyc(1, 3'd0, 32'h2AAAA);
        chk("data_out", 32'(out_port), 32'h2AAAA);
        rd(3'd0, v);
        chk("data_rd", v, 32'h0002AAAA);

        // Mixed direction read-back
        cyc(1, 3'd1, 32'h0000F);
        cyc(1, 3'd0, 32'h3FFFF);
        in_port = 18'h00A50;
        cyc(0, 3'd0, 32'h0);
        cyc(0, 3'd0, 32'h0);
        rd(3'd0, v);
        chk("mixed_rd", v, 32'h00A5F);

        // Rising edge capture and interrupt
        in_port = '0;
        repeat (3) cyc(0, 3'd0, 32'h0);
        cyc(1, 3'd3, 32'h3FFFF);
        cyc(1, 3'd2, 32'h1);
        chk("irq_idle", 32'(irq), 32'h0);
        in_port[0] = 1'b1;
        cyc(0, 3'd0, 32'h0);
        cyc(0, 3'd0, 32'h0);
        chk("irq_k1", 32'(irq), 32'h0);
        cyc(0, 3'd0, 32'h0);
        chk("irq_k2", 32'(irq), 32'h1);
        rd(3'd3, v);
        chk("edgecap_k2", v, 32'h1);
        cyc(1, 3'd3, 32'h1);
        chk("irq_cleared", 32'(irq), 32'h0);

        // Edge coinciding with write-1-clear: edge wins
        in_port[0] = 1'b0;
        repeat (3) cyc(0, 3'd0, 32'h0);
        in_port[0] = 1'b1;
        repeat (3) cyc(0, 3'd0, 32'h0);
        chk("irq_pre_race", 32'(irq), 32'h1);
        in_port[0] = 1'b0;
        repeat (3) cyc(0, 3'd0, 32'h0);
        in_port[0] = 1'b1;
        cyc(0, 3'd0, 32'h0);
        cyc(0, 3'd0, 32'h0);
        cyc(1, 3'd3, 32'h1);
        chk("irq_race", 32'(irq), 32'h1);
        rd(3'd3, v);
        chk("edgecap_race", v, 32'h1);
        cyc(1, 3'd3, 32'h1);
        chk("irq_after_race", 32'(irq), 32'h0);

        // Set/clear registers
        cyc(1, 3'd1, 32'h3FFFF);
        cyc(1, 3'd0, 32'h000F0);
        cyc(1, 3'd4, 32'h0000F);
`ifdef NIOS2VGA_GPIO_SETCLR_EN
        chk("outset", 32'(out_port), 32'h000FF);
`else
        chk("outset", 32'(out_port), 32'h000F0);
`endif
        cyc(1, 3'd5, 32'h000F0);
`ifdef NIOS2VGA_GPIO_SETCLR_EN
        chk("outclr", 32'(out_port), 32'h0000F);
`else
        chk("outclr", 32'(out_port), 32'h000F0);
`endif
        rd(3'd4, v);
        chk("outset_rd", v, 32'h0);

        // Reserved addresses
        cyc(1, 3'd6, 32'hFFFFFFFF);
        cyc(1, 3'd7, 32'hFFFFFFFF);
        rd(3'd6, v);
        chk("rsvd6_rd", v, 32'h0);
        rd(3'd7, v);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            logic [2:0] ra;
            if ($urandom_range(0, 2) == 0) in_port = in_port ^ DW'($urandom & $urandom);
            ra = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 1) == 1) cyc(1, ra, $urandom);
            else cyc(0, ra, 32'h0);
            rd(3'($urandom_range(0, 7)), v);
        end

        // Asynchronous reset with a pending interrupt
        cyc(1, 3'd2, 32'h3FFFF);
        in_port = '0;
        repeat (3) cyc(0, 3'd0, 32'h0);
        in_port = ALL;
        repeat (3) cyc(0, 3'd0, 32'h0);
        chk("irq_pre_reset", 32'(irq), 32'h1);
        #2;
        reset_n = 1'b0;
        #1;
        chk("async_irq", 32'(irq), 32'h0);
        chk("async_out_port", 32'(out_port), 32'h155);
        chk("async_out_en", 32'(out_en), 32'h3FFFF);
        m_reset();
        @(negedge clk);
        reset_n = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 0) in_port = in_port ^ DW'($urandom);
            cyc($urandom_range(0, 1) == 1, 3'($urandom_range(0, 7)), $urandom);
            rd(3'($urandom_range(0, 3)), v);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
